// File: rtl/psg_pkg.sv
// Shared constants and types for the PSG envelope path.
// ENVELOPE_FINE_EN selects the 32-step YM2149 envelope instead of the 16-step AY one.
package psg_pkg;

  localparam int SHAPE_CONTINUE  = 3;
  localparam int SHAPE_ATTACK    = 2;
  localparam int SHAPE_ALTERNATE = 1;
  localparam int SHAPE_HOLD      = 0;

`ifdef ENVELOPE_FINE_EN
  localparam int ENV_STEP_BITS = 5;
`else
  localparam int ENV_STEP_BITS = 4;
`endif

  localparam int ENV_STEPS = 1 << ENV_STEP_BITS;

  typedef logic [ENV_STEP_BITS-1:0] env_level_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } env_state_t;

  // Rising phases output the step count directly, falling phases its complement.
  function automatic env_level_t shape_level(input env_level_t step, input logic up);
    return up ? step : ~step;
  endfunction

endpackage

// File: rtl/period_divider.sv
// Programmable tick divider: emits a one-cycle tick every max(period,1) enabled cycles.
// Also suitable for the tone and noise generators.
module period_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   count_inc;
  logic [WIDTH:0]   limit;

  // One bit wider so the compare never wraps when period is all ones.
  assign count_inc = {1'b0, count} + 1'b1;
  assign limit     = (period == '0) ? (WIDTH+1)'(1) : {1'b0, period};
  assign tick      = clk_en && (count_inc >= limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (clk_en) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/envelope_controller.sv
// AY-3-8910 style envelope generator plus per-channel volume-source select.
// Defining ENVELOPE_FINE_EN switches to 32-step YM2149 mode and adds envelope_lsb.
module envelope_controller
  import psg_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int PERIOD_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [PERIOD_BITS-1:0]    period,
  input  logic [3:0]                shape,
  input  logic                      restart,
  input  logic [5*NUM_CHANNELS-1:0] volume,
  output logic [3:0]                envelope,
  output logic [4*NUM_CHANNELS-1:0] control
`ifdef ENVELOPE_FINE_EN
  ,
  output logic                      envelope_lsb
`endif
);

  localparam env_level_t LEVEL_MAX = env_level_t'(ENV_STEPS - 1);

  env_state_t state, state_next;
  logic [3:0] shape_q;
  env_level_t step, step_next;
  env_level_t level_q, level_next;
  logic       flip, flip_next;
  logic       step_evt;
  logic [3:0] env_next;

  period_divider #(
    .WIDTH(PERIOD_BITS)
  ) u_divider (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .clear (restart),
    .period(period),
    .tick  (step_evt)
  );

  // Restart wins over a coincident step event; the held level is simply the last level_q.
  always_comb begin
    state_next = state;
    step_next  = step;
    flip_next  = flip;
    level_next = level_q;
    if (restart) begin
      state_next = ST_RUN;
      step_next  = '0;
      flip_next  = 1'b0;
      level_next = shape_level('0, shape[SHAPE_ATTACK]);
    end else if (state == ST_RUN && step_evt) begin
      if (step == LEVEL_MAX) begin
        if (!shape_q[SHAPE_CONTINUE]) begin
          state_next = ST_HOLD;
          level_next = '0;
        end else if (shape_q[SHAPE_HOLD]) begin
          state_next = ST_HOLD;
          level_next = (shape_q[SHAPE_ATTACK] ^ shape_q[SHAPE_ALTERNATE]) ? LEVEL_MAX : '0;
        end else begin
          step_next  = '0;
          flip_next  = flip ^ shape_q[SHAPE_ALTERNATE];
          level_next = shape_level('0, shape_q[SHAPE_ATTACK] ^ flip_next);
        end
      end else begin
        step_next  = step + 1'b1;
        level_next = shape_level(step_next, shape_q[SHAPE_ATTACK] ^ flip);
      end
    end
  end

  assign env_next = level_next[ENV_STEP_BITS-1 -: 4];

  // Control uses the next envelope value so both outputs move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      shape_q <= 4'h0;
      step    <= '0;
      flip    <= 1'b0;
      level_q <= LEVEL_MAX;
      control <= '0;
    end else begin
      state   <= state_next;
      step    <= step_next;
      flip    <= flip_next;
      level_q <= level_next;
      if (restart) begin
        shape_q <= shape;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        control[4*c +: 4] <= volume[5*c+4] ? env_next : volume[5*c +: 4];
      end
    end
  end

  assign envelope = level_q[ENV_STEP_BITS-1 -: 4];

`ifdef ENVELOPE_FINE_EN
  assign envelope_lsb = level_q[0];
`endif

endmodule

// File: tb/tb_envelope_controller.sv
// Directed self-checking bench for envelope_controller (default 16-step build).
// Expected envelope/control values are hand-derived from the shape definitions.
module tb_envelope_controller;

  localparam int NUM_CHANNELS = 3;
  localparam int PERIOD_BITS  = 16;
  localparam logic [14:0] VOL_DEFAULT = {5'h10, 5'h07, 5'h10};
  localparam logic [14:0] VOL_CH0_FIXED = {5'h10, 5'h07, 5'h05};

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic restart;
  logic [PERIOD_BITS-1:0] period;
  logic [3:0] shape;
  logic [5*NUM_CHANNELS-1:0] volume;
  logic [3:0] envelope;
  logic [4*NUM_CHANNELS-1:0] control;
`ifdef ENVELOPE_FINE_EN
  logic envelope_lsb;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  envelope_controller #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .PERIOD_BITS (PERIOD_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .period  (period),
    .shape   (shape),
    .restart (restart),
    .volume  (volume),
    .envelope(envelope),
    .control (control)
`ifdef ENVELOPE_FINE_EN
    ,
    .envelope_lsb(envelope_lsb)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] p, input logic [3:0] s, input logic r);
    period  = p;
    shape   = s;
    restart = r;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // With VOL_DEFAULT, channels 0 and 2 follow the envelope and channel 1 is fixed at 7.
  function automatic logic [15:0] ctl(input logic [3:0] e);
    return {4'h0, e, 4'h7, e};
  endfunction

  // Triangle (shape E): 0..15, 15..0, 0..15 over 48 levels.
  function automatic logic [3:0] tri_level(input int k);
    if (k < 16) return 4'(k);
    else if (k < 32) return 4'(31 - k);
    else return 4'(k - 32);
  endfunction

  initial begin
    reset   = 1'b1;
    clk_en  = 1'b1;
    restart = 1'b0;
    period  = 16'd1;
    shape   = 4'h0;
    volume  = VOL_DEFAULT;
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset_env", {12'h0, envelope}, 16'h000F);
    checkOutput("reset_ctl", {4'h0, control}, 16'h0000);

    $display("[TB] shape D attack-and-hold, period 1");
    reset = 1'b0;
    applyStimulus(16'd1, 4'hD, 1'b1);
    tick();
    restart = 1'b0;
    checkOutput("d_env[0]", {12'h0, envelope}, 16'h0000);
    checkOutput("d_ctl[0]", {4'h0, control}, ctl(4'h0));
    for (int i = 1; i < 16; i++) begin
      tick();
      checkOutput($sformatf("d_env[%0d]", i), {12'h0, envelope}, 16'(i));
      checkOutput($sformatf("d_ctl[%0d]", i), {4'h0, control}, ctl(4'(i)));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("d_hold[%0d]", i), {12'h0, envelope}, 16'h000F);
    end

    $display("[TB] shape E triangle, period 2");
    applyStimulus(16'd2, 4'hE, 1'b1);
    tick();
    restart = 1'b0;
    for (int n = 0; n < 96; n++) begin
      checkOutput($sformatf("e_env[%0d]", n), {12'h0, envelope}, {12'h0, tri_level(n / 2)});
      tick();
    end

    $display("[TB] shape 8 saw-down, period 0 then period 1");
    applyStimulus(16'd0, 4'h8, 1'b1);
    tick();
    restart = 1'b0;
    for (int n = 0; n < 20; n++) begin
      checkOutput($sformatf("p0_env[%0d]", n), {12'h0, envelope}, 16'(15 - (n % 16)));
      tick();
    end
    applyStimulus(16'd1, 4'h8, 1'b1);
    tick();
    restart = 1'b0;
    for (int n = 0; n < 20; n++) begin
      checkOutput($sformatf("p1_env[%0d]", n), {12'h0, envelope}, 16'(15 - (n % 16)));
      tick();
    end

    $display("[TB] clk_en low freezes the envelope");
    applyStimulus(16'd1, 4'h8, 1'b1);
    tick();
    restart = 1'b0;
    tick();
    checkOutput("en_run", {12'h0, envelope}, 16'h000E);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("en_frozen[%0d]", i), {12'h0, envelope}, 16'h000E);
    end
    clk_en = 1'b1;
    tick();
    checkOutput("en_resume", {12'h0, envelope}, 16'h000D);

    $display("[TB] restart to shape B over a coincident step event");
    applyStimulus(16'd1, 4'h0, 1'b1);
    tick();
    restart = 1'b0;
    tick();
    checkOutput("s0_env[1]", {12'h0, envelope}, 16'h000E);
    tick();
    checkOutput("s0_env[2]", {12'h0, envelope}, 16'h000D);
    applyStimulus(16'd1, 4'hB, 1'b1);
    tick();
    restart = 1'b0;
    checkOutput("b_env[0]", {12'h0, envelope}, 16'h000F);
    for (int n = 1; n < 16; n++) begin
      tick();
      checkOutput($sformatf("b_env[%0d]", n), {12'h0, envelope}, 16'(15 - n));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("b_hold[%0d]", i), {12'h0, envelope}, 16'h000F);
    end

    $display("[TB] channel 0 volume-source toggle");
    volume = VOL_CH0_FIXED;
    checkOutput("vol_before", {4'h0, control}, 16'h0F7F);
    tick();
    checkOutput("vol_fixed", {4'h0, control}, 16'h0F75);
    volume = VOL_DEFAULT;
    tick();
    checkOutput("vol_env", {4'h0, control}, 16'h0F7F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
